// File: rtl/sobel_line_scheduler_if.sv
// Pixel-in, line-buffer and window-out signals of the Sobel line scheduler.
// The scheduler takes the slave side; its environment takes the master side.
interface sobel_line_scheduler_if;
  logic [7:0]  i_pixel_data;
  logic        i_pixel_data_valid;
  logic        o_in_ready;
  logic [3:0]  o_lb_wr_en;
  logic [7:0]  o_lb_wr_data;
  logic [3:0]  o_lb_rd_en;
  logic [23:0] i_lb_rd_data0;
  logic [23:0] i_lb_rd_data1;
  logic [23:0] i_lb_rd_data2;
  logic [23:0] i_lb_rd_data3;
  logic [71:0] o_pixel_data;
  logic        o_pixel_data_valid;
  logic        o_intr;

  modport slave (
    input  i_pixel_data,
    input  i_pixel_data_valid,
    output o_in_ready,
    output o_lb_wr_en,
    output o_lb_wr_data,
    output o_lb_rd_en,
    input  i_lb_rd_data0,
    input  i_lb_rd_data1,
    input  i_lb_rd_data2,
    input  i_lb_rd_data3,
    output o_pixel_data,
    output o_pixel_data_valid,
    output o_intr
  );

  modport master (
    output i_pixel_data,
    output i_pixel_data_valid,
    input  o_in_ready,
    input  o_lb_wr_en,
    input  o_lb_wr_data,
    input  o_lb_rd_en,
    output i_lb_rd_data0,
    output i_lb_rd_data1,
    output i_lb_rd_data2,
    output i_lb_rd_data3,
    input  o_pixel_data,
    input  o_pixel_data_valid,
    input  o_intr
  );
endinterface

// File: rtl/sobel_line_scheduler.sv
// Round-robin line-buffer writer and 3-line window reader
// feeding the Sobel convolver.
module sobel_line_scheduler #(
  parameter int IMG_WIDTH = 512,
  parameter int CNT_W     = 12
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  sobel_line_scheduler_if.slave bus
);

  localparam int CW = $clog2(IMG_WIDTH);

  localparam logic [CW-1:0] LAST =
    CW'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] W_F =
    CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] THR =
    CNT_W'(3 * IMG_WIDTH);
  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(4 * IMG_WIDTH);

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [1:0]       wr_sel;
  logic [CW-1:0]    wr_cnt;
  logic [1:0]       rd_base;
  logic [CW-1:0]    rd_cnt;
  logic [CNT_W-1:0] fill;
  logic             intr_q;

  logic             acc;
  logic             line_end;
  logic [3:0]       rd_en;
  logic             pvalid;
  logic [7:0]       rot;
  logic [1:0]       b1;
  logic [1:0]       b2;
  logic [23:0]      lb [4];

  assign bus.o_in_ready = (fill < FULL);
  assign acc = bus.i_pixel_data_valid
             & bus.o_in_ready;
  assign line_end = (state == READ)
                  & (rd_cnt == LAST);

  assign bus.o_lb_wr_en =
    acc ? (4'b0001 << wr_sel) : 4'b0000;
  assign bus.o_lb_wr_data = bus.i_pixel_data;

  // Three-of-four mask rotated so bit rd_base is the top row
  assign rot = {4'b0111, 4'b0111} << rd_base;

  always_comb begin
    state_n = state;
    rd_en   = 4'b0000;
    pvalid  = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (fill >= THR && !intr_q)
          state_n = READ;
      end
      (state == READ): begin
        rd_en  = rot[7:4];
        pvalid = 1'b1;
        if (rd_cnt == LAST)
          state_n = IDLE;
      end
    endcase
  end

  assign bus.o_lb_rd_en = rd_en;
  assign bus.o_pixel_data_valid = pvalid;
  assign bus.o_intr = intr_q;

  assign lb[0] = bus.i_lb_rd_data0;
  assign lb[1] = bus.i_lb_rd_data1;
  assign lb[2] = bus.i_lb_rd_data2;
  assign lb[3] = bus.i_lb_rd_data3;
  assign b1 = rd_base + 2'd1;
  assign b2 = rd_base + 2'd2;

  assign bus.o_pixel_data =
    {lb[b2], lb[b1], lb[rd_base]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      wr_sel  <= '0;
      wr_cnt  <= '0;
      rd_base <= '0;
      rd_cnt  <= '0;
      fill    <= '0;
      intr_q  <= 1'b0;
    end else begin
      state  <= state_n;
      intr_q <= line_end;
      if (acc) begin
        if (wr_cnt == LAST) begin
          wr_cnt <= '0;
          wr_sel <= wr_sel + 2'd1;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (state == READ) begin
        if (line_end) begin
          rd_cnt  <= '0;
          rd_base <= rd_base + 2'd1;
        end else begin
          rd_cnt  <= rd_cnt + 1'b1;
        end
      end
      // Freeing a line and accepting a pixel can coincide
      fill <= fill + CNT_W'(acc)
            - (line_end ? W_F : '0);
    end
  end

endmodule
